// File: rtl/addsub_accum_ctrl.sv
// addsub_accum_ctrl: handshake-driven accumulator that sequences an external add/sub stage
module addsub_accum_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam logic [1:0] OP_SUB = 2'b01;
  state_t state;
  logic [1:0] op_reg;
  logic [WIDTH-1:0] acc, opnd_reg, b;
  assign add_x = acc;
  assign add_y = state == EXEC ? opnd_reg : '0;
  assign add_cin = state == EXEC && op_reg == OP_SUB;
  assign b = opnd_reg ^ {WIDTH{add_cin}};
  assign out_data = acc;
  assign out_z = acc == '0;
  assign out_n = acc[WIDTH-1];
  // op_reg[1] selects LOAD/CLEAR, which bypass the adder and clear the flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      op_reg <= '0;
      opnd_reg <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_c <= 1'b0;
      out_v <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_reg <= in_op;
          opnd_reg <= in_data;
          in_ready <= 1'b0;
          state <= EXEC;
        end
        EXEC: begin
          acc <= op_reg[1] ? (op_reg[0] ? '0 : opnd_reg) : add_s;
          out_c <= !op_reg[1] && add_cout;
          out_v <= !op_reg[1] && (acc[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != acc[WIDTH-1]);
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_accum_ctrl.sv
// tb_addsub_accum_ctrl: scoreboard bench with a behavioural 4-bit add/sub stage on the adder ports
module tb_addsub_accum_ctrl;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [1:0] in_op = 0;
  logic [3:0] in_data = 0, add_x, add_y, add_s, out_data;
  logic add_cin, add_cout, out_c, out_v, out_z, out_n;
  logic [4:0] sum5;
  int errors = 0, checks = 0, accepts = 0, acc0;
  typedef struct packed {logic [3:0] d; logic c; logic v;} exp_t;
  exp_t q[$];
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

  always #5 clk = ~clk;

  assign sum5 = {1'b0, add_x} + {1'b0, add_y ^ {4{add_cin}}} + {4'b0, add_cin};
  assign add_s = sum5[3:0];
  assign add_cout = sum5[4];

  addsub_accum_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .add_x(add_x), .add_y(add_y), .add_cin(add_cin), .add_s(add_s),
    .add_cout(add_cout), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n)
  );

  function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) if (!rst && in_valid && in_ready) accepts++;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none at %0t", out_data, $time);
      end else begin
        e = q.pop_front();
        check("out_data", {4'b0, out_data}, {4'b0, e.d});
        check("out_c", {7'b0, out_c}, {7'b0, e.c});
        check("out_v", {7'b0, out_v}, {7'b0, e.v});
        check("out_z", {7'b0, out_z}, {7'b0, e.d == 4'h0});
        check("out_n", {7'b0, out_n}, {7'b0, e.d[3]});
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] d, input logic [3:0] ed,
                      input logic ec, input logic ev);
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_op = op; in_data = d;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", {7'b0, in_ready}, 8'h1);
      in_valid = 0;
      return;
    end
    q.push_back('{ed, ec, ev});
    @(negedge clk);
    in_valid = 0; in_op = ~op; in_data = ~d;
    check("lat_exec_valid", {7'b0, out_valid}, 8'h0);
    @(negedge clk);
    check("lat_done_valid", {7'b0, out_valid}, 8'h1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {7'b0, out_valid}, 8'h0);
    check("rst_in_ready", {7'b0, in_ready}, 8'h1);
    check("rst_out_data", {4'b0, out_data}, 8'h0);
    check("rst_out_z", {7'b0, out_z}, 8'h1);
    rst = 0;
    send(LOAD, 4'h5, 4'h5, 0, 0);
    send(ADD, 4'h3, 4'h8, 0, 1);
    send(SUB, 4'h8, 4'h0, 1, 0);
    send(SUB, 4'h1, 4'hF, 0, 0);
    send(ADD, 4'h1, 4'h0, 1, 0);
    send(LOAD, 4'h7, 4'h7, 0, 0);
    send(ADD, 4'h1, 4'h8, 0, 1);
    send(CLR, 4'h9, 4'h0, 0, 0);
    send(LOAD, 4'h8, 4'h8, 0, 0);
    // stall in DONE with a pending command waiting
    @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    in_valid = 1; in_op = LOAD; in_data = 4'h3;
    acc0 = accepts;
    q.push_back('{4'h3, 1'b0, 1'b0});
    @(negedge clk);
    in_op = ADD; in_data = 4'h1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {7'b0, out_valid}, 8'h1);
      check("stall_in_ready", {7'b0, in_ready}, 8'h0);
      check("stall_data", {4'b0, out_data}, 8'h3);
      @(negedge clk);
    end
    check("stall_accepts", 8'(accepts - acc0), 8'h1);
    q.push_back('{4'h4, 1'b0, 1'b0});
    @(posedge clk); #1 out_ready = 1;
    repeat (3) @(negedge clk);
    in_valid = 0;
    check("release_accepts", 8'(accepts - acc0), 8'h2);
    @(negedge clk);
    send(LOAD, 4'h5, 4'h5, 0, 0);
    // reset lands while ADD 3 is executing
    @(negedge clk);
    in_valid = 1; in_op = ADD; in_data = 4'h3;
    @(negedge clk);
    in_valid = 0;
    check("exec_add_y", {4'b0, add_y}, 8'h3);
    check("exec_add_x", {4'b0, add_x}, 8'h5);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst_out_valid", {7'b0, out_valid}, 8'h0);
    check("midrst_in_ready", {7'b0, in_ready}, 8'h1);
    check("midrst_out_data", {4'b0, out_data}, 8'h0);
    repeat (4) @(negedge clk);
    check("queue_empty", 8'(q.size()), 8'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
